// File: rtl/opnd_pkg.sv
// Shared types, constant table and pointer helpers for the operand-fetch controller.
package opnd_pkg;

    // Default pointer and data widths.
    localparam int OPND_PW = 5;
    localparam int OPND_DW = 8;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        CAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Which operand register(s) the data of the outstanding read belongs to.
    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_A    = 2'd1,
        PEND_B    = 2'd2,
        PEND_AB   = 2'd3
    } pend_t;

    // Constant operands, selected by the low four pointer bits when the MSB is set.
    localparam logic [7:0] CONST_TABLE [16] = '{
        8'd127, 8'd1,  8'd2,  8'd128,
        8'd8,   8'd3,  8'd4,  8'd5,
        8'd32,  8'd6,  8'd15, 8'd64,
        8'd7,   8'd255, 8'd19, 8'd20
    };

    // A pointer with its MSB set names a constant rather than a register.
    function automatic logic is_const(input logic [OPND_PW-1:0] ptr);
        return ptr[OPND_PW-1];
    endfunction

endpackage

// File: rtl/opnd_if.sv
// Bus bundle around the operand-fetch controller: decode-side request,
// register-file read port and execute-side result handshake.
// master = the fetch controller, slave = the stages/RF around it.
interface opnd_if #(
    parameter int PW = 5,
    parameter int DW = 8
);
    // Decode-side pointer pair.
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] ptr_a;
    logic [PW-1:0] ptr_b;

    // Shared register-file read port.
    logic          rf_rd_en;
    logic [PW-2:0] rf_addr;
    logic [DW-1:0] rf_rdata;

    // Execute-side resolved operands.
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] opnd_a;
    logic [DW-1:0] opnd_b;
    logic          a_is_const;
    logic          b_is_const;

    modport master (
        input  in_valid, ptr_a, ptr_b, rf_rdata, out_ready,
        output in_ready, rf_rd_en, rf_addr,
        output out_valid, opnd_a, opnd_b, a_is_const, b_is_const
    );

    modport slave (
        output in_valid, ptr_a, ptr_b, rf_rdata, out_ready,
        input  in_ready, rf_rd_en, rf_addr,
        input  out_valid, opnd_a, opnd_b, a_is_const, b_is_const
    );

endinterface

// File: rtl/const_rom.sv
// Combinational constant ROM: 4-bit index to a zero-extended DW-bit value.
module const_rom
    import opnd_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    idx_i,
    output logic [DW-1:0] data_o
);

    assign data_o = DW'(CONST_TABLE[idx_i]);

endmodule

// File: rtl/opnd_fetch_ctrl.sv
// Operand-fetch controller: resolves a pointer pair to two operands, using the
// constant ROM for constant pointers and the single RF read port for registers.
module opnd_fetch_ctrl
    import opnd_pkg::*;
#(
    parameter int PW = OPND_PW,
    parameter int DW = OPND_DW
) (
    input  logic   clk,
    input  logic   reset,
    opnd_if.master bus
);

    // Incoming pointers as an array so both ROM lookups share one generate loop.
    logic [PW-1:0] ptr_in   [2];
    logic [DW-1:0] rom_val  [2];
    logic          in_const [2];

    assign ptr_in[0] = bus.ptr_a;
    assign ptr_in[1] = bus.ptr_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rom
            const_rom #(
                .DW (DW)
            ) u_const_rom (
                .idx_i  (ptr_in[gi][3:0]),
                .data_o (rom_val[gi])
            );
            assign in_const[gi] = is_const(ptr_in[gi]);
        end
    endgenerate

    state_t        state_q;
    pend_t         pend_q;
    logic [PW-1:0] ptr_a_q;
    logic [PW-1:0] ptr_b_q;
    logic [DW-1:0] opnd_a_q;
    logic [DW-1:0] opnd_b_q;
    logic          a_const_q;
    logic          b_const_q;

    // Properties of the latched pair used while reads are in flight.
    logic b_reg;
    logic ptr_eq;

    assign b_reg  = !ptr_b_q[PW-1];
    assign ptr_eq = (ptr_a_q == ptr_b_q);

    // Sequencer: accept, issue up to two reads, capture returning data, present result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pend_q    <= PEND_NONE;
            ptr_a_q   <= '0;
            ptr_b_q   <= '0;
            opnd_a_q  <= '0;
            opnd_b_q  <= '0;
            a_const_q <= 1'b0;
            b_const_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        ptr_a_q   <= ptr_in[0];
                        ptr_b_q   <= ptr_in[1];
                        // Constants resolve on the accept edge; registers wait for the RF.
                        opnd_a_q  <= in_const[0] ? rom_val[0] : '0;
                        opnd_b_q  <= in_const[1] ? rom_val[1] : '0;
                        a_const_q <= in_const[0];
                        b_const_q <= in_const[1];
                        pend_q    <= PEND_NONE;
                        if (!in_const[0]) begin
                            state_q <= RD_A;
                        end else if (!in_const[1]) begin
                            state_q <= RD_B;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                RD_A: begin
                    // A shared register is read once and later fans out to both operands.
                    if (b_reg && !ptr_eq) begin
                        pend_q  <= PEND_A;
                        state_q <= RD_B;
                    end else begin
                        pend_q  <= b_reg ? PEND_AB : PEND_A;
                        state_q <= CAP;
                    end
                end
                RD_B: begin
                    // Data for the read issued in RD_A arrives while B's read is issued.
                    if (pend_q == PEND_A) begin
                        opnd_a_q <= bus.rf_rdata;
                    end
                    pend_q  <= PEND_B;
                    state_q <= CAP;
                end
                CAP: begin
                    unique case (pend_q)
                        PEND_A:  opnd_a_q <= bus.rf_rdata;
                        PEND_B:  opnd_b_q <= bus.rf_rdata;
                        PEND_AB: begin
                            opnd_a_q <= bus.rf_rdata;
                            opnd_b_q <= bus.rf_rdata;
                        end
                        default: ;
                    endcase
                    pend_q  <= PEND_NONE;
                    state_q <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // RF read strobe and address are decoded straight from the state.
    always_comb begin
        bus.rf_rd_en = 1'b0;
        bus.rf_addr  = '0;
        unique case (state_q)
            RD_A: begin
                bus.rf_rd_en = 1'b1;
                bus.rf_addr  = ptr_a_q[PW-2:0];
            end
            RD_B: begin
                bus.rf_rd_en = 1'b1;
                bus.rf_addr  = ptr_b_q[PW-2:0];
            end
            default: ;
        endcase
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.opnd_a     = opnd_a_q;
    assign bus.opnd_b     = opnd_b_q;
    assign bus.a_is_const = a_const_q;
    assign bus.b_is_const = b_const_q;

endmodule
